// File: rtl/line_win_scanner_if.sv
// Handshake and result bundle between the game controller and the line scanner.
// The controller drives start/board; the scanner returns status and results.
interface line_win_scanner_if #(
  parameter int N  = 3,
  parameter int LW = $clog2(2*N+2)
) ();
  logic              start;
  logic [2*N*N-1:0]  board;
  logic              busy;
  logic              done;
  logic              winner;
  logic [1:0]        who;
  logic [LW-1:0]     win_line;
  logic              draw;
  logic              err;

  modport master (
    output start, board,
    input  busy, done, winner, who, win_line, draw, err
  );

  modport slave (
    input  start, board,
    output busy, done, winner, who, win_line, draw, err
  );
endinterface

// File: rtl/line_win_scanner.sv
// Sequential NxN tic-tac-toe winner detector. A board snapshot is taken on an
// accepted start, then one line (rows, columns, main diag, anti diag, in that
// order) is checked per clock. The first winning line ends the scan early.
module line_win_scanner #(
  parameter int N  = 3,
  parameter int LW = $clog2(2*N+2)
) (
  input  logic               clk,
  input  logic               reset_n,
  line_win_scanner_if.slave  bus
);

  localparam int NL = 2*N + 2;          // number of lines on the board
  localparam int NT = 2**LW;            // line table padded to the index range
  localparam logic [LW-1:0] LAST_LINE = LW'(2*N + 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state_reg,    state_next;
  logic [LW-1:0]    idx_reg,      idx_next;
  logic [2*N*N-1:0] snap_reg,     snap_next;
  logic             winner_reg,   winner_next;
  logic [1:0]       who_reg,      who_next;
  logic [LW-1:0]    win_line_reg, win_line_next;
  logic             draw_reg,     draw_next;
  logic             err_reg,      err_next;

  // Per-cell flags: illegal cells on the incoming board, empty cells in the snapshot.
  logic [N*N-1:0] cell_ill;
  logic [N*N-1:0] snap_empty;

  genvar gi, gk;

  for (gi = 0; gi < N*N; gi++) begin : g_cellflag
    assign cell_ill[gi]   = &bus.board[2*gi +: 2];
    assign snap_empty[gi] = ~|snap_reg[2*gi +: 2];
  end

  // Win flag and common code for every line, indexed by line number. Entries
  // beyond the last real line are tied off so the index mux stays in range.
  logic [NT-1:0] line_win;
  logic [1:0]    line_code [NT];

  for (gi = 0; gi < NT; gi++) begin : g_line
    if (gi < NL) begin : g_real
      logic [2*N-1:0] cells;
      for (gk = 0; gk < N; gk++) begin : g_cell
        localparam int R = (gi < N) ? gi : gk;
        localparam int C = (gi < N)    ? gk :
                           (gi < 2*N)  ? (gi - N) :
                           (gi == 2*N) ? gk : (N - 1 - gk);
        assign cells[2*gk +: 2] = snap_reg[2*(R*N + C) +: 2];
      end
      // Only all-X or all-O lines win; empty and illegal codes never do.
      assign line_win[gi]  = (cells == {N{2'b01}}) || (cells == {N{2'b10}});
      assign line_code[gi] = cells[1:0];
    end else begin : g_pad
      assign line_win[gi]  = 1'b0;
      assign line_code[gi] = 2'b00;
    end
  end

  // State and result registers; reset aborts any scan in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      snap_reg     <= '0;
      winner_reg   <= 1'b0;
      who_reg      <= 2'b00;
      win_line_reg <= '0;
      draw_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      snap_reg     <= snap_next;
      winner_reg   <= winner_next;
      who_reg      <= who_next;
      win_line_reg <= win_line_next;
      draw_reg     <= draw_next;
      err_reg      <= err_next;
    end
  end

  // Next-state and result update: capture on start, one line per SCAN cycle.
  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    snap_next     = snap_reg;
    winner_next   = winner_reg;
    who_next      = who_reg;
    win_line_next = win_line_reg;
    draw_next     = draw_reg;
    err_next      = err_reg;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          snap_next     = bus.board;
          idx_next      = '0;
          winner_next   = 1'b0;
          who_next      = 2'b00;
          win_line_next = '0;
          draw_next     = 1'b0;
          // An illegal cell makes the position meaningless, so skip the scan.
          if (|cell_ill) begin
            err_next   = 1'b1;
            state_next = DONE;
          end else begin
            err_next   = 1'b0;
            state_next = SCAN;
          end
        end
      end
      SCAN: begin
        if (line_win[idx_reg]) begin
          winner_next   = 1'b1;
          who_next      = line_code[idx_reg];
          win_line_next = idx_reg;
          state_next    = DONE;
        end else if (idx_reg == LAST_LINE) begin
          draw_next  = ~|snap_empty;
          state_next = DONE;
        end else begin
          idx_next = idx_reg + LW'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.busy     = (state_reg != IDLE);
  assign bus.done     = (state_reg == DONE);
  assign bus.winner   = winner_reg;
  assign bus.who      = who_reg;
  assign bus.win_line = win_line_reg;
  assign bus.draw     = draw_reg;
  assign bus.err      = err_reg;

endmodule

// File: tb/tb_line_win_scanner.sv
// Directed bench for line_win_scanner: one N=3 and one N=4 instance, boards
// written as row-major strings ('.' empty, 'X', 'O', '#' illegal).
module tb_line_win_scanner;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  line_win_scanner_if #(.N(3)) if3 ();
  line_win_scanner_if #(.N(4)) if4 ();

  line_win_scanner #(.N(3)) dut3 (.clk(clk), .reset_n(reset_n), .bus(if3));
  line_win_scanner #(.N(4)) dut4 (.clk(clk), .reset_n(reset_n), .bus(if4));

  int n_assert = 0;
  int n_fail   = 0;

  // Selected-DUT view so one set of tasks serves both instances.
  logic       sel4 = 1'b0;
  logic       s_busy, s_done, s_winner, s_draw, s_err;
  logic [1:0] s_who;
  logic [3:0] s_line;
  assign s_busy   = sel4 ? if4.busy   : if3.busy;
  assign s_done   = sel4 ? if4.done   : if3.done;
  assign s_winner = sel4 ? if4.winner : if3.winner;
  assign s_who    = sel4 ? if4.who    : if3.who;
  assign s_line   = sel4 ? if4.win_line : {1'b0, if3.win_line};
  assign s_draw   = sel4 ? if4.draw   : if3.draw;
  assign s_err    = sel4 ? if4.err    : if3.err;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] mk(input string s);
    logic [63:0] b;
    b = '0;
    for (int i = 0; i < s.len(); i++) begin
      case (s[i])
        "X": b[2*i +: 2] = 2'b01;
        "O": b[2*i +: 2] = 2'b10;
        "#": b[2*i +: 2] = 2'b11;
        default: b[2*i +: 2] = 2'b00;
      endcase
    end
    return b;
  endfunction

  task automatic drive(input logic st, input logic [63:0] b);
    if (sel4) begin
      if4.start = st;
      if4.board = b[31:0];
    end else begin
      if3.start = st;
      if3.board = b[17:0];
    end
  endtask

  task automatic release_start();
    if3.start = 1'b0;
    if4.start = 1'b0;
  endtask

  // Launch a scan (start sampled at edge 0), optionally pulse start with another
  // board in cycle poke_cyc, and check done timing, busy and the post-done cycle.
  task automatic scan(input string tag, input logic [63:0] b, input int exp_cyc,
                      input int poke_cyc, input logic [63:0] poke_b);
    int  done_cyc;
    bit  got;
    bit  busy_ok;
    done_cyc = -1;
    got      = 1'b0;
    busy_ok  = 1'b1;
    @(negedge clk);
    drive(1'b1, b);
    @(posedge clk);
    #1;
    release_start();
    for (int c = 1; c <= 40; c++) begin
      if (s_done) begin
        got      = 1'b1;
        done_cyc = c;
      end
      if (!s_busy) busy_ok = 1'b0;
      if (c == poke_cyc) drive(1'b1, poke_b);
      @(posedge clk);
      #1;
      release_start();
      if (got) break;
    end
    check({tag, "_done_cycle"}, done_cyc, exp_cyc);
    check({tag, "_busy_during"}, {31'd0, busy_ok}, 32'd1);
    check({tag, "_done_after"}, {31'd0, s_done}, 32'd0);
    check({tag, "_busy_after"}, {31'd0, s_busy}, 32'd0);
  endtask

  task automatic results(input string tag, input logic w, input logic [1:0] who,
                         input logic [3:0] line, input logic d, input logic e);
    check({tag, "_winner"},   {31'd0, s_winner}, {31'd0, w});
    check({tag, "_who"},      {30'd0, s_who},    {30'd0, who});
    check({tag, "_win_line"}, {28'd0, s_line},   {28'd0, line});
    check({tag, "_draw"},     {31'd0, s_draw},   {31'd0, d});
    check({tag, "_err"},      {31'd0, s_err},    {31'd0, e});
  endtask

  initial begin
    bit seen_done;
    if3.start = 1'b0; if3.board = '0;
    if4.start = 1'b0; if4.board = '0;

    // Reset state
    #2;
    sel4 = 1'b0;
    check("rst3_busy", {31'd0, s_busy}, 32'd0);
    check("rst3_done", {31'd0, s_done}, 32'd0);
    results("rst3", 1'b0, 2'b00, 4'd0, 1'b0, 1'b0);
    sel4 = 1'b1;
    #1;
    check("rst4_busy", {31'd0, s_busy}, 32'd0);
    results("rst4", 1'b0, 2'b00, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    sel4 = 1'b0;
    // Row 0 win, earliest possible done; start pulsed in the DONE cycle is ignored
    scan("row0", mk("XXX......"), 2, 2, mk("OOO......"));
    results("row0", 1'b1, 2'b01, 4'd0, 1'b0, 1'b0);
    $display("row0: winner=%0d who=%0b line=%0d", s_winner, s_who, s_line);

    // Anti-diagonal is the last line scanned
    scan("anti", mk("XXOXOXOX."), 9, 0, '0);
    results("anti", 1'b1, 2'b10, 4'd7, 1'b0, 1'b0);
    $display("anti: winner=%0d who=%0b line=%0d", s_winner, s_who, s_line);

    // Full board, no line: draw
    scan("draw", mk("XOXXOOOXX"), 9, 0, '0);
    results("draw", 1'b0, 2'b00, 4'd0, 1'b1, 1'b0);
    $display("draw: draw=%0d", s_draw);

    // Illegal cell aborts before scanning, even with a complete row present
    scan("ill", mk("XXX.#...."), 1, 0, '0);
    results("ill", 1'b0, 2'b00, 4'd0, 1'b0, 1'b1);
    $display("ill: err=%0d", s_err);
    scan("allill", mk("#########"), 1, 0, '0);
    results("allill", 1'b0, 2'b00, 4'd0, 1'b0, 1'b1);
    $display("allill: err=%0d", s_err);

    // Two winning rows: lowest index reported
    scan("two", mk("XXX...OOO"), 2, 0, '0);
    results("two", 1'b1, 2'b01, 4'd0, 1'b0, 1'b0);
    $display("two: who=%0b line=%0d", s_who, s_line);

    // Start with a new board during SCAN is ignored; row 2 still wins at cycle 4
    scan("ign", mk("......OOO"), 4, 2, mk("XXX......"));
    results("ign", 1'b1, 2'b10, 4'd2, 1'b0, 1'b0);
    $display("ign: who=%0b line=%0d", s_who, s_line);

    // Reset in cycle 3 of a scan: outputs cleared, no done pulse
    @(negedge clk);
    drive(1'b1, mk("XOXXOOOXX"));
    @(posedge clk); #1; release_start();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("rstmid_busy", {31'd0, s_busy}, 32'd0);
    results("rstmid", 1'b0, 2'b00, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    seen_done = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (s_done || s_busy) seen_done = 1'b1;
    end
    check("rstmid_no_done", {31'd0, seen_done}, 32'd0);
    results("rstmid_after", 1'b0, 2'b00, 4'd0, 1'b0, 1'b0);
    $display("rstmid: busy=%0d done_seen=%0d", s_busy, seen_done);

    // N=4: column 3 of O
    sel4 = 1'b1;
    scan("n4col3", mk("...O...O...O...O"), 9, 0, '0);
    results("n4col3", 1'b1, 2'b10, 4'd7, 1'b0, 1'b0);
    $display("n4col3: who=%0b line=%0d", s_who, s_line);

    // N=4: empty board, full scan, not a draw
    scan("n4empty", mk("................"), 11, 0, '0);
    results("n4empty", 1'b0, 2'b00, 4'd0, 1'b0, 1'b0);
    $display("n4empty: winner=%0d draw=%0d", s_winner, s_draw);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
